// File: rtl/dac_player_pkg.sv
// dac_player_pkg: shared state encoding and sizing helpers for the DAC loop player
package dac_player_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;
    localparam int STALL_W = 32;
    function automatic int ratio_f(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction
endpackage

// File: rtl/dac_player_sdp_ram.sv
// dac_player_sdp_ram: inferred simple-dual-port RAM with a 1-cycle registered read
module dac_player_sdp_ram
    import dac_player_pkg::*;
#(
    parameter int W     = 256,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/dac_loop_player.sv
// dac_loop_player: loads a waveform into an SDP RAM and replays it to the DAC as OUT_W beats
module dac_loop_player
    import dac_player_pkg::*;
#(
    parameter int IN_W   = 256,
    parameter int OUT_W  = 128,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH),
    parameter int LOOP_W = 16
) (
    input  logic                rf_clk,
    input  logic                rf_rst,
    input  logic [IN_W-1:0]     s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [OUT_W-1:0]    m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic [AW:0]         cfg_len,
    input  logic [LOOP_W-1:0]   cfg_loops,
    input  logic                cfg_load,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    output logic                busy,
    output logic                loaded,
    output logic [AW:0]         loaded_len,
    output logic [LOOP_W-1:0]   loops_done,
    output logic [STALL_W-1:0]  stall_cnt,
    output logic                err_start
);
    localparam int RATIO = ratio_f(IN_W, OUT_W);
    localparam int BW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
    state_e state_q, state_d;
    logic [AW:0] len_q, wr_ptr_q, loaded_len_q;
    logic [AW-1:0] rd_ptr_q, out_ptr_q, rd_addr;
    logic [LOOP_W-1:0] loops_q, loops_done_q;
    logic [STALL_W-1:0] stall_q;
    logic [BW-1:0] beat_q;
    logic [IN_W-1:0] fifo_q [2];
    logic [IN_W-1:0] ram_rdata;
    logic [RATIO-1:0][OUT_W-1:0] head;
    logic [1:0] occ_q;
    logic loaded_q, err_q, wp_q, rp_q, rv_q;
    logic we, wr_last, go, re, hs, pop, push, word_end, done;
    assign we = state_q == LOAD && s_axis_tvalid;
    assign wr_last = we && (s_axis_tlast || wr_ptr_q == len_q - 1'b1 || &wr_ptr_q[AW-1:0]);
    assign go = state_q == IDLE && cfg_start && !cfg_load && loaded_q && cfg_len != '0;
    assign rd_addr = state_q == PLAY ? rd_ptr_q : '0;
    // Reads run one cycle ahead of the skid; a read is issued only if its word will have a slot.
    assign re = go || (state_q == PLAY && 3'(occ_q) + 3'(rv_q) < 3'd2 + 3'(pop));
    assign push = rv_q && state_q == PLAY;
    assign hs = m_axis_tvalid && m_axis_tready;
    assign pop = hs && beat_q == LAST_BEAT;
    assign word_end = pop && {1'b0, out_ptr_q} == loaded_len_q - 1'b1;
    assign done = word_end && loops_q != '0 && loops_done_q + 1'b1 == loops_q;
    assign head = fifo_q[rp_q];
    assign m_axis_tvalid = state_q == PLAY && occ_q != '0;
    assign m_axis_tdata = m_axis_tvalid ? head[beat_q] : '0;
    assign s_axis_tready = state_q == LOAD;
    assign busy = state_q != IDLE;
    assign loaded = loaded_q;
    assign loaded_len = loaded_len_q;
    assign loops_done = loops_done_q;
    assign stall_cnt = stall_q;
    assign err_start = err_q;
    dac_player_sdp_ram #(.W(IN_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (rf_clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (s_axis_tdata),
        .re_i    (re),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = cfg_load ? LOAD : go ? PLAY : IDLE;
        if (state_q == LOAD && (cfg_abort || wr_last)) state_d = IDLE;
        if (state_q == PLAY && (cfg_abort || done)) state_d = IDLE;
    end
    always_ff @(posedge rf_clk) begin
        if (rf_rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            wr_ptr_q     <= '0;
            loaded_len_q <= '0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
            rd_ptr_q     <= '0;
            out_ptr_q    <= '0;
            loops_q      <= '0;
            loops_done_q <= '0;
            stall_q      <= '0;
            beat_q       <= '0;
            occ_q        <= '0;
            wp_q         <= 1'b0;
            rp_q         <= 1'b0;
            rv_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            rv_q    <= re;
            if (state_q == IDLE && cfg_load) begin
                len_q    <= cfg_len;
                wr_ptr_q <= '0;
                loaded_q <= 1'b0;
            end
            if (state_q == IDLE && cfg_start && !cfg_load && (!loaded_q || cfg_len == '0)) err_q <= 1'b1;
            if (we) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (state_q == LOAD && !cfg_abort && wr_last) begin
                loaded_q     <= 1'b1;
                loaded_len_q <= wr_ptr_q + 1'b1;
            end
            if (go) begin
                loops_q      <= cfg_loops;
                loops_done_q <= '0;
                stall_q      <= '0;
                out_ptr_q    <= '0;
                beat_q       <= '0;
            end
            if (re) rd_ptr_q <= {1'b0, rd_addr} == loaded_len_q - 1'b1 ? '0 : rd_addr + 1'b1;
            if (hs) beat_q <= pop ? '0 : beat_q + 1'b1;
            if (pop) out_ptr_q <= word_end ? '0 : out_ptr_q + 1'b1;
            if (word_end) loops_done_q <= loops_done_q + 1'b1;
            if (m_axis_tvalid && !m_axis_tready && ~&stall_q) stall_q <= stall_q + 1'b1;
            if (push) wp_q <= !wp_q;
            if (pop) rp_q <= !rp_q;
            occ_q <= state_q == PLAY ? occ_q + 2'(push) - 2'(pop) : '0;
            if (state_q != PLAY) begin
                wp_q <= 1'b0;
                rp_q <= 1'b0;
            end
        end
    end
    always_ff @(posedge rf_clk) begin
        if (push) fifo_q[wp_q] <= ram_rdata;
    end
endmodule

// File: tb/tb_dac_loop_player.sv
// tb_dac_loop_player: randomized scoreboard bench for dac_loop_player
module tb_dac_loop_player;
    localparam int IN_W = 256, OUT_W = 128, DEPTH = 1024, AW = 10, LOOP_W = 16;
    localparam int RATIO = IN_W / OUT_W;
    logic clk = 1'b0, rst = 1'b1;
    logic [IN_W-1:0] s_tdata = '0;
    logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [OUT_W-1:0] m_tdata;
    logic m_tvalid, m_tready = 1'b1;
    logic [AW:0] cfg_len = '0;
    logic [LOOP_W-1:0] cfg_loops = '0;
    logic cfg_load = 1'b0, cfg_start = 1'b0, cfg_abort = 1'b0;
    logic busy, loaded, err_start;
    logic [AW:0] loaded_len;
    logic [LOOP_W-1:0] loops_done;
    logic [31:0] stall_cnt;
    int checks = 0, passed = 0, beats = 0, model_len = 0;
    logic [IN_W-1:0] model_mem [DEPTH];
    logic [OUT_W-1:0] exp_q [$];

    dac_loop_player #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LOOP_W(LOOP_W)) dut (
        .rf_clk(clk), .rf_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .cfg_len(cfg_len), .cfg_loops(cfg_loops), .cfg_load(cfg_load), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .busy(busy), .loaded(loaded), .loaded_len(loaded_len), .loops_done(loops_done),
        .stall_cnt(stall_cnt), .err_start(err_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output stream from the start of a play: word (b/RATIO) mod len, slice b mod RATIO.
    task automatic push_beats(input int n);
        for (int b = 0; b < n; b++)
            exp_q.push_back(OUT_W'(model_mem[(b / RATIO) % model_len] >> ((b % RATIO) * OUT_W)));
    endtask

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL beat_unexpected: got %0h, no beat expected", m_tdata);
            end else chk("beat_data", m_tdata, exp_q.pop_front());
        end
    end

    task automatic do_load(input int len, input int last_at, input bit pattern);
        logic [IN_W-1:0] w;
        bit ok = 1'b1;
        cfg_len = (AW+1)'(len);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(3) == 0) begin
                s_tvalid = 1'b0;
                step();
            end
            if (pattern) w = {16{16'(i + 1)}};
            else for (int j = 0; j < IN_W / 32; j++) w = {w[IN_W-33:0], 32'($urandom())};
            s_tdata = w;
            s_tlast = (i == last_at);
            s_tvalid = 1'b1;
            if (!s_tready) ok = 1'b0;
            step();
            model_mem[i] = w;
            if (i == last_at) break;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        model_len = (last_at >= 0 && last_at < len) ? last_at + 1 : len;
        chk("load_ready", ok, 1);
        chk("loaded", loaded, 1);
        chk("loaded_len", loaded_len, model_len);
        chk("tready_drop", s_tready, 0);
    endtask

    task automatic play_run(input int loops);
        int lat = 1, run = 0, n;
        n = loops * model_len * RATIO;
        m_tready = 1'b1;
        cfg_loops = LOOP_W'(loops);
        push_beats(n);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        while (!m_tvalid && lat < 10) begin
            step();
            lat++;
        end
        chk("first_valid_latency", lat, 2);
        while (m_tvalid && run < n + 10) begin
            step();
            run++;
        end
        chk("gapless_beats", run, n);
        chk("loops_done", loops_done, loops);
        chk("busy_end", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n, b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_loaded_len", loaded_len, 0);
        chk("rst_loops_done", loops_done, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_err", err_start, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tready", s_tready, 0);

        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("err_no_load", err_start, 1);
        chk("err_busy", busy, 0);
        repeat (2) begin
            chk("err_tvalid", m_tvalid, 0);
            step();
        end

        do_load(4, -1, 1'b1);
        play_run(2);

        do_load(8, 2, 1'b0);
        play_run(1);

        do_load(5, -1, 1'b0);
        push_beats(400);
        beats = 0;
        cfg_loops = '0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        for (int i = 0; i < 200; i++) begin
            m_tready = (i % 2 == 0);
            step();
        end
        m_tready = 1'b1;
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("abort_tvalid", m_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_loaded", loaded, 1);
        chk("stall_cnt", stall_cnt, 100);
        chk("toggle_beats", beats, 101);
        chk("cont_loops_done", loops_done, (101 / RATIO) / model_len);
        exp_q.delete();

        push_beats(200);
        beats = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        n = 0;
        while (beats < 5 && n < 50) begin
            step();
            n++;
        end
        chk("reach_beat5", beats, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tvalid", m_tvalid, 0);
        chk("mid_rst_tdata", m_tdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_loaded", loaded, 0);
        chk("mid_rst_loaded_len", loaded_len, 0);
        chk("mid_rst_loops_done", loops_done, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_err", err_start, 0);
        b0 = beats;
        repeat (5) step();
        chk("no_beats_after_rst", beats, b0);
        exp_q.delete();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("err_after_rst", err_start, 1);
        chk("busy_after_rst", busy, 0);
        step();
        chk("tvalid_after_rst", m_tvalid, 0);

        do_load(DEPTH, -1, 1'b0);
        play_run(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
